// File: rtl/enc_8to3_seq.sv
// enc_8to3_seq: sequential 8-to-3 encoder.
// Takes an 8-bit vector and emits the 3-bit index of each set bit, one index
// per output beat, in priority order (LSB-first by default, MSB-first when
// MSB_FIRST=1). The zero vector produces one beat flagged with out_none.
//
// Handshake semantics (both ports): a transfer happens on a rising edge
// where valid && ready are both 1. A producer holding valid keeps its data
// stable until the transfer. Ready may depend on the other port in the same
// cycle (in_ready rises on the last-beat transfer cycle), but valid/data
// never depend on ready.
module enc_8to3_seq #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] out,
    output logic       out_last,
    output logic       out_none,
    output logic       dbg_state,
    output logic [7:0] dbg_pending
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] pending_q, pending_d;
    logic       zero_q, zero_d;

    logic [2:0] sel_idx;
    logic       at_most_one;
    logic       in_fire;
    logic       out_fire;

    // Index of the highest-priority remaining bit; the last match in loop order wins.
    always_comb begin
        sel_idx = 3'd0;
        if (MSB_FIRST) begin
            for (int i = 0; i < 8; i++) begin
                if (pending_q[i]) sel_idx = 3'(i);
            end
        end else begin
            for (int i = 7; i >= 0; i--) begin
                if (pending_q[i]) sel_idx = 3'(i);
            end
        end
    end

    // Clearing the lowest set bit leaves zero only when at most one bit was set.
    assign at_most_one = ((pending_q & (pending_q - 8'd1)) == 8'd0);

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // State and datapath registers; reset wins over any handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= 8'd0;
            zero_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            zero_q    <= zero_d;
        end
    end

    // Next state: retire the emitted bit, then let a newly accepted vector overwrite.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        zero_d    = zero_q;
        if (out_fire) begin
            pending_d = pending_q & ~(8'd1 << sel_idx);
            if (out_last) zero_d = 1'b0;
        end
        if (in_fire) begin
            pending_d = in;
            zero_d    = (in == 8'd0);
        end
        case (state_q)
            IDLE: begin
                if (in_fire) state_d = EMIT;
            end
            EMIT: begin
                if (out_fire && out_last) state_d = in_fire ? EMIT : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs from registered state only; in_ready also opens on the last-beat transfer.
    always_comb begin
        out_valid = 1'b0;
        out       = 3'd0;
        out_last  = 1'b0;
        out_none  = 1'b0;
        if (state_q == EMIT) begin
            out_valid = 1'b1;
            out       = zero_q ? 3'd0 : sel_idx;
            out_last  = zero_q || at_most_one;
            out_none  = zero_q;
        end
        in_ready = !rst && ((state_q == IDLE) || (out_ready && out_last));
    end

    assign dbg_state   = (state_q == EMIT);
    assign dbg_pending = pending_q;

endmodule
